// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding the UART TX port: packs 1 or 2 bytes (DATA_BITS=16) per TX_DATA word, one TX_DATA_VAL strobe each.
// Latency: byte accepted at edge E0 strobes after E2 (8-bit); IN_RDY drops when full, issue waits for TX_BUSY low.
// Optional UART_TX_FEEDER_LEVEL_EN adds FIFO_LEVEL / FIFO_HALF outputs.
module uart_tx_feeder #(
  parameter int DEPTH      = 64,
  parameter int BUSY_GUARD = 4
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic [7:0]              DATA_BITS,
  input  logic                    FLUSH,
  input  logic [7:0]              IN_DATA,
  input  logic                    IN_VAL,
  output logic                    IN_RDY,
  output logic [15:0]             TX_DATA,
  output logic                    TX_DATA_VAL,
  input  logic                    TX_BUSY,
  output logic                    FIFO_EMPTY
`ifdef UART_TX_FEEDER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]  FIFO_LEVEL,
  output logic                    FIFO_HALF
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (BUSY_GUARD > 1) ? $clog2(BUSY_GUARD) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);
  localparam logic [AW:0]   TWO  = (AW+1)'(2);
  localparam logic [AW-1:0] PONE = AW'(1);

  typedef enum logic [2:0] {IDLE, LOAD_LO, LOAD_HI, ISSUE, GUARD, WAIT_IDLE} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt, need_now;
  logic          in_rdy_q, wide_q, wide_now, wr_en, pop;
  logic [7:0]    lo_mask, mask_now;
  logic [GW-1:0] guard_cnt;

  // A write coinciding with FLUSH is dropped; a flushed LOAD state pops nothing.
  assign wr_en    = IN_VAL & in_rdy_q & ~FLUSH;
  assign pop      = ((state == LOAD_LO) || (state == LOAD_HI)) & ~FLUSH;
  assign wide_now = (DATA_BITS == 8'd16);
  assign need_now = wide_now ? TWO : ONE;

  always_comb begin
    case (DATA_BITS)
      8'd5:    mask_now = 8'h1F;
      8'd6:    mask_now = 8'h3F;
      8'd7:    mask_now = 8'h7F;
      default: mask_now = 8'hFF;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (FLUSH)
      count_nxt = '0;
    else if (wr_en && !pop)
      count_nxt = count + ONE;
    else if (!wr_en && pop)
      count_nxt = count - ONE;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_rdy_q <= 1'b1;
    end else begin
      if (FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PONE;
        if (pop)   rd_ptr <= rd_ptr + PONE;
      end
      count    <= count_nxt;
      in_rdy_q <= (count_nxt != FULL);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= IN_DATA;
  end

  assign IN_RDY     = in_rdy_q;
  assign FIFO_EMPTY = (count == '0);

`ifdef UART_TX_FEEDER_LEVEL_EN
  localparam logic [AW:0] HALF = (AW+1)'(DEPTH / 2);
  assign FIFO_LEVEL = count;
  assign FIFO_HALF  = (count >= HALF);
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= IDLE;
      TX_DATA     <= 16'h0000;
      TX_DATA_VAL <= 1'b0;
      wide_q      <= 1'b0;
      lo_mask     <= 8'hFF;
      guard_cnt   <= '0;
    end else begin
      TX_DATA_VAL <= 1'b0;
      case (state)
        IDLE: begin
          if (!TX_BUSY && (count >= need_now) && !FLUSH) begin
            wide_q  <= wide_now;
            lo_mask <= mask_now;
            state   <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (FLUSH) begin
            state <= IDLE;
          end else begin
            TX_DATA <= {8'h00, mem[rd_ptr] & lo_mask};
            if (wide_q) begin
              state <= LOAD_HI;
            end else begin
              state       <= ISSUE;
              TX_DATA_VAL <= 1'b1;
            end
          end
        end
        LOAD_HI: begin
          if (FLUSH) begin
            state <= IDLE;
          end else begin
            TX_DATA[15:8] <= mem[rd_ptr];
            state         <= ISSUE;
            TX_DATA_VAL   <= 1'b1;
          end
        end
        ISSUE: begin
          guard_cnt <= GW'(BUSY_GUARD - 1);
          state     <= GUARD;
        end
        // ISSUE plus the GUARD cycles together span BUSY_GUARD cycles of ignored TX_BUSY.
        GUARD: begin
          if (guard_cnt <= GW'(1))
            state <= WAIT_IDLE;
          else
            guard_cnt <= guard_cnt - GW'(1);
        end
        WAIT_IDLE: begin
          if (!TX_BUSY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte-wide transmit buffer and issue controller that sits directly upstream of the UART top-level transmit port. It accepts bytes from the USB bulk-OUT side with a valid/ready handshake and stores them in a FIFO. It packs the bytes into TX_DATA words (1 byte, or 2 bytes when DATA_BITS=16) and issues one TX_DATA_VAL pulse per word. Issue is gated by TX_BUSY, which already includes CTS flow control.

Parameters:
DEPTH, 64, FIFO depth in bytes; power of 2, minimum 4
BUSY_GUARD, 4, cycles to ignore TX_BUSY after a TX_DATA_VAL pulse (covers the UART busy-rise latency); minimum 1

Ports:
CLK  in  1  system clock
RSTN  in  1  asynchronous active-low reset
DATA_BITS  in  8  word format: 5/6/7/8 = one byte per word, 16 = two bytes per word; other values are treated as 8
FLUSH  in  1  synchronous FIFO clear, single-cycle pulse
IN_DATA  in  8  byte from the USB side
IN_VAL  in  1  IN_DATA is valid
IN_RDY  out  1  FIFO can accept a byte; a transfer occurs when IN_VAL=1 and IN_RDY=1 at a rising CLK edge
TX_DATA  out  16  word to the UART transmitter
TX_DATA_VAL  out  1  one-cycle issue strobe
TX_BUSY  in  1  UART busy or CTS deasserted
FIFO_EMPTY  out  1  FIFO byte count is 0

Behaviour:
- Reset (RSTN=0, asynchronous):
  - count=0, pointers=0, state=IDLE.
  - TX_DATA=16'h0000, TX_DATA_VAL=0, IN_RDY=1, FIFO_EMPTY=1.
- FIFO:
  - Storage is DEPTH×8 with a registered count of width log2(DEPTH)+1.
  - IN_RDY = (count != DEPTH), registered, so writes are blocked while full even if a pop happens in the same cycle.
  - A write and a pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - No read-through: a byte written into an empty FIFO becomes poppable on the next cycle.
- need = 2 when DATA_BITS=16, else 1. DATA_BITS is sampled when leaving IDLE and held for the rest of that word.
- State machine:
  - IDLE: go to LOAD_LO when TX_BUSY=0, count>=need, and FLUSH=0.
  - LOAD_LO: pop one byte into TX_DATA[7:0].
    - For 5/6/7 data bits, bits at index DATA_BITS and above are forced to 0.
    - TX_DATA[15:8] is set to 0.
    - Next state: LOAD_HI if need=2, else ISSUE.
  - LOAD_HI: pop one byte into TX_DATA[15:8] (little-endian: first byte received is the LSB). Next state: ISSUE.
  - ISSUE: TX_DATA_VAL=1 for exactly this cycle. TX_DATA is stable from the LOAD exit until the next LOAD. Next state: GUARD with guard counter = BUSY_GUARD-1.
  - GUARD: ignore TX_BUSY; decrement the counter; go to WAIT_IDLE when it reaches 0.
  - WAIT_IDLE: return to IDLE when TX_BUSY=0.
- Latency: with the FIFO empty and TX_BUSY=0, a byte accepted at edge E0 gives TX_DATA_VAL high after edge E2 (8-bit mode). In 16-bit mode the second byte accepted at E0 gives TX_DATA_VAL high after E3.
- Minimum spacing between TX_DATA_VAL pulses: need + 1 + BUSY_GUARD + 1 cycles.
- FLUSH:
  - count and pointers are cleared at the next edge.
  - A FLUSH during LOAD_LO or LOAD_HI aborts to IDLE with no TX_DATA_VAL, and the partially packed word is discarded.
  - A FLUSH during ISSUE, GUARD or WAIT_IDLE does not cancel the word already issued.
  - A write accepted in the same cycle as FLUSH is dropped.
- 16-bit mode holding one byte: stays in IDLE indefinitely. Switching DATA_BITS to 8 allows the byte to issue.
- TX_BUSY held high (CTS deasserted): the FIFO fills and IN_RDY drops at count=DEPTH. No byte is ever lost or duplicated.

Optional Feature:
- Macro: UART_TX_FEEDER_LEVEL_EN.
- Defined: adds output port FIFO_LEVEL [log2(DEPTH):0] equal to the registered count, and output FIFO_HALF, set to 1 when count>=DEPTH/2. Used by USB endpoint NAK pacing.
- Undefined: neither port exists and no extra logic is generated. All other behaviour is identical.

Test Plan:
- Reset then idle with TX_BUSY=0 -> TX_DATA=0, TX_DATA_VAL=0, IN_RDY=1, FIFO_EMPTY=1; no strobe ever.
- DATA_BITS=8, write 0x55,0xAA, model UART busy for 20 cycles after each strobe (rising 2 cycles after the strobe) -> exactly two strobes; TX_DATA=0x0055, then 0x00AA; first strobe 2 edges after acceptance.
- DATA_BITS=16, write 0x34,0x12,0x78 -> one strobe with TX_DATA=0x1234; 0x78 stays buffered (FIFO_EMPTY=0); after DATA_BITS changes to 8 -> strobe with TX_DATA=0x0078.
- DATA_BITS=7, write 0xFF -> TX_DATA=0x007F.
- TX_BUSY=1 (CTS high), DEPTH=64, stream 70 bytes 0..69 -> IN_RDY=0 after 64 accepted; release TX_BUSY -> bytes 0..69 issued in order, none lost or duplicated.
- Write 3 bytes with TX_BUSY=1, pulse FLUSH in the same cycle as a fourth write, then release TX_BUSY -> FIFO_EMPTY=1, no strobe; a following write of 0x42 -> single strobe with 0x0042.
